// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package serial_add_pkg;

    // FSM state encoding; value 3 is unused and treated as illegal.
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from gate primitives.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b, cin -> z (sum bit), cout (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor u_x1 (ab_x, a, b);
    xor u_x2 (z, ab_x, cin);
    and u_a1 (ab_a, a, b);
    and u_a2 (cx_a, ab_x, cin);
    or  u_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder reused LSB first over WIDTH bits with a registered carry.
// Latency: start accepted at edge 0 -> busy cycles 1..WIDTH, done pulse in cycle WIDTH+1.
// Backpressure: start is only accepted while ready=1; requests at any other time are dropped.
// Ports: clk, reset (sync, active-high), start/a/b/cin in; ready, busy, done, sum, cout out.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_z;
    logic             fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .z    (fa_z),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_LAST);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
    always_comb begin
        sum_nx            = sum_sh >> 1;
        sum_nx[WIDTH-1]   = fa_z;
    end

    // Next-state logic; the illegal encoding falls back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start)    state_nx = ST_RUN;
            ST_RUN:  if (last_bit) state_nx = ST_DONE;
            ST_DONE:               state_nx = ST_IDLE;
            default:               state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                ST_RUN: begin
                    sum_sh <= sum_nx;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= sum_nx;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags come from the state register only.
    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       reset8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, cout8;
    logic [7:0] sum8;

    // WIDTH=1 instance
    logic       reset1 = 1'b1, start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ready1, busy1, done1, cout1;
    logic [0:0] sum1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_sum;
        logic exp_cout;
    } vec1_t;

    // Issue one WIDTH=8 addition and check latency, busy span, result and ready return.
    task automatic do_op8(input vec8_t v);
        int n;
        int busy_n;
        @(negedge clk);
        chk("w8_ready_before", ready8, 1);
        a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~v.a; b8 = ~v.b; cin8 = ~v.cin;   // operands may change after acceptance
        n = 1; busy_n = 0;
        while (!done8 && n < 40) begin
            if (busy8) busy_n++;
            @(negedge clk);
            n++;
        end
        chk("w8_done_cycle", n, 9);
        chk("w8_busy_cycles", busy_n, 8);
        chk("w8_sum", sum8, v.exp_sum);
        chk("w8_cout", cout8, v.exp_cout);
        @(negedge clk);
        chk("w8_done_one_cycle", done8, 0);
        chk("w8_ready_after", ready8, 1);
    endtask

    task automatic do_op1(input vec1_t v);
        int n;
        @(negedge clk);
        a1 = v.a; b1 = v.b; cin1 = v.cin; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        n = 1;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w1_done_cycle", n, 2);
        chk("w1_sum", sum1, v.exp_sum);
        chk("w1_cout", cout1, v.exp_cout);
    endtask

    vec8_t t8[7];
    vec1_t t1[8];

    initial begin
        int n, dones;
        logic [7:0] seen_sum;
        logic [8:0] exp_q[$];
        logic [8:0] e;
        int issued, last_done, got;

        t8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        t8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        t8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        t8[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        t8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        t8[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        t8[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        t1[0] = '{0, 0, 0, 0, 0};
        t1[1] = '{0, 0, 1, 1, 0};
        t1[2] = '{0, 1, 0, 1, 0};
        t1[3] = '{0, 1, 1, 0, 1};
        t1[4] = '{1, 0, 0, 1, 0};
        t1[5] = '{1, 0, 1, 0, 1};
        t1[6] = '{1, 1, 0, 0, 1};
        t1[7] = '{1, 1, 1, 1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        reset8 = 1'b0; reset1 = 1'b0;
        chk("rst_ready", ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        chk("rst1_ready", ready1, 1);

        for (int i = 0; i < 7; i++) do_op8(t8[i]);

        // Second start during RUN is ignored: one done pulse, sum 12+34.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0; seen_sum = '0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 4) begin a8 = 8'hFF; start8 = 1'b1; end
            if (c == 7) start8 = 1'b0;
            if (done8) begin dones++; seen_sum = sum8; end
            @(negedge clk);
        end
        chk("ign_done_pulses", dones, 1);
        chk("ign_sum", seen_sum, 8'h46);

        // Reset mid-run discards the operation.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);             // now in cycle 5
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        chk("mid_rst_ready", ready8, 1);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_sum", sum8, 0);
        chk("mid_rst_cout", cout8, 0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", dones, 0);

        // Reset and start on the same edge: reset wins.
        a8 = 8'h01; b8 = 8'h01; reset8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0; start8 = 1'b0;
        chk("rst_start_ready", ready8, 1);
        chk("rst_start_busy", busy8, 0);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) do_op1(t1[i]);

        // start held high: three back-to-back operations, done every 10 cycles.
        @(negedge clk);
        issued = 0; got = 0; last_done = -1;
        start8 = 1'b1;
        for (int c = 0; c < 200 && got < 3; c++) begin
            if (done8) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_result", {cout8, sum8}, e);
                end else begin
                    chk("b2b_unexpected_done", 1, 0);
                end
                if (last_done >= 0) chk("b2b_spacing", c - last_done, 10);
                last_done = c;
                got++;
            end
            if (ready8) begin
                if (issued < 3) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                    exp_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
                    issued++;
                end else begin
                    start8 = 1'b0;
                end
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        chk("b2b_done_count", got, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
